pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 43 ++++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the hazard/exception controller.
// master: the pipeline side raising requests; slave: the controller answering with holds.
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        excp_req;
    logic [31:0] excp_vec;
    logic        halt_req;
    logic        resume_req;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        halted;
    logic        stall_timeout;

    modport master (
        output stallreq_id,
        output stallreq_ex,
        output excp_req,
        output excp_vec,
        output halt_req,
        output resume_req,
        input  stall,
        input  flush,
        input  new_pc,
        input  halted,
        input  stall_timeout
    );

    modport slave (
        input  stallreq_id,
        input  stallreq_ex,
        input  excp_req,
        input  excp_vec,
        input  halt_req,
        input  resume_req,
        output stall,
        output flush,
        output new_pc,
        output halted,
        output stall_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / exception / debug-halt controller.
// Produces per-stage hold bits, a one-cycle flush with redirect address, a drain-then-halt
// sequence for debug, and a sticky watchdog for stalls that never resolve.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned STALL_LIMIT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES);
    localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);
    localparam logic [7:0]        WdLimit   = 8'(STALL_LIMIT);

    // Hold patterns, bit 0 = pc up to bit 5 = wb
    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallFe   = 6'b000011;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallAll  = 6'b111111;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StDrain,
        StHalted
    } state_e;

    state_e             state_q, state_d;
    logic [DrainW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [31:0]        vec_q, vec_d;
    logic [7:0]         wd_q, wd_d;
    logic               timeout_q, timeout_d;

    logic [5:0]         stall_c;
    logic               flush_c;

    // Next-state, counters and raw (pre-reset-gating) outputs
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        vec_d       = vec_q;
        wd_d        = 8'd0;
        timeout_d   = timeout_q;
        stall_c     = StallNone;
        flush_c     = 1'b0;

        unique case (state_q)
            StRun: begin
                if (bus.stallreq_ex) begin
                    stall_c = StallEx;
                end else if (bus.stallreq_id) begin
                    stall_c = StallId;
                end
                if (bus.excp_req) begin
                    stall_c = StallAll;
                    vec_d   = bus.excp_vec;
                    state_d = StFlush;
                end else if (bus.halt_req) begin
                    state_d     = StDrain;
                    drain_cnt_d = DrainLoad;
                end
                // Watchdog only counts while we stay in RUN; leaving RUN clears it
                if (state_d == StRun && stall_c != StallNone) begin
                    wd_d = (wd_q >= WdLimit) ? wd_q : wd_q + 8'd1;
                    if (wd_d == WdLimit) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (bus.stallreq_ex) begin
                    stall_c = StallEx;
                end else if (bus.stallreq_id) begin
                    stall_c = StallId;
                end else begin
                    stall_c = StallFe;
                end
                if (bus.excp_req) begin
                    stall_c = StallAll;
                    vec_d   = bus.excp_vec;
                    state_d = StFlush;
                end else if (stall_c == StallFe) begin
                    // Only bubble cycles that actually advance the back end count
                    drain_cnt_d = drain_cnt_q - DrainOne;
                    if (drain_cnt_q <= DrainOne) begin
                        state_d = StHalted;
                    end
                end
            end
            StFlush: begin
                flush_c = 1'b1;
                state_d = StRun;
            end
            StHalted: begin
                stall_c = StallAll;
                if (bus.resume_req) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State and counter registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            drain_cnt_q <= '0;
            vec_q       <= 32'h0;
            wd_q        <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            vec_q       <= vec_d;
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
        end
    end

    // Outputs forced low while reset is held; new_pc comes only from the register
    always_comb begin
        bus.stall         = rst ? StallNone : stall_c;
        bus.flush         = ~rst & flush_c;
        bus.new_pc        = rst ? 32'h0 : vec_q;
        bus.halted        = ~rst & (state_q == StHalted);
        bus.stall_timeout = ~rst & timeout_q;
    end

endmodule
